register_file_mp: RTL and testbench
===================================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter DATA_W, default 8: register width in bits.
REQ-002 Parameter DEPTH, default 16: number of registers, power of two, 4..256.
REQ-003 Parameter NUM_RD, default 2: number of read ports, 1..4.
REQ-004 Parameter REG_READ, default 0: 0 = combinational read; 1 = read data registered, one-cycle latency.
REQ-005 Parameter BYPASS, default 1: 1 = same-cycle write data forwarded to reads.
REQ-006 Parameter ZERO_REG, default 0: 1 = register 0 hardwired to zero, never busy.
REQ-007 Derived constant ADDR_W = clog2(DEPTH).
REQ-008 clk  input  1  single clock, all state updates on rising edge.
REQ-009 reset  input  1  reset is synchronous and active-high.
REQ-010 rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 rd_data  output  NUM_RD*DATA_W  packed read data, port i at bits [i*DATA_W +: DATA_W].
REQ-012 rd_busy  output  NUM_RD  scoreboard busy bit of each addressed register.
REQ-013 wr0_en / wr0_addr / wr0_data  input  1 / ADDR_W / DATA_W  write port 0.
REQ-014 wr1_en / wr1_addr / wr1_data  input  1 / ADDR_W / DATA_W  write port 1, higher priority.
REQ-015 rsv_en / rsv_addr  input  1 / ADDR_W  reserve: set busy bit of rsv_addr.
REQ-016 busy_vec  output  DEPTH  busy bit of every register, registered.

Function
REQ-017 Writes SHALL take effect at the rising edge where wrN_en=1; the register holds the value from the following cycle.
REQ-018 wr0 and wr1 to the same address in one cycle: wr1_data SHALL be stored, wr0 discarded.
REQ-019 Any write to address A SHALL clear busy bit A at the same edge.
REQ-020 rsv_en=1 SHALL set busy bit rsv_addr at the edge; reserve plus write to the same address in one cycle: data stored, busy ends set (reserve wins).
REQ-021 REG_READ=0: rd_data[i] SHALL equal the stored value of rd_addr[i] in the same cycle.
REQ-022 REG_READ=1: rd_data[i] and rd_busy[i] SHALL reflect rd_addr[i] sampled at the previous edge, with the write results of that edge applied.
REQ-023 BYPASS=1, REG_READ=0: a read of an address written this cycle SHALL return that write's data (wr1 over wr0) and rd_busy SHALL show the post-edge busy value.
REQ-024 BYPASS=0, REG_READ=0: reads SHALL return pre-write data; no forwarding.
REQ-025 ZERO_REG=1: writes and reserves to address 0 SHALL be ignored; reads of 0 return 0, busy 0.
REQ-026 Out-of-range addresses cannot occur (DEPTH power of two); no error output.

Reset
REQ-027 While reset=1 at an edge, all registers, busy_vec and registered rd_data SHALL become 0; writes and reserves that cycle SHALL be ignored.
REQ-028 Reset asserted mid-operation SHALL discard pending reservations; first write accepted at the first edge with reset=0.
REQ-029 During reset, combinational rd_data SHALL show stored values, no bypass (all 0 after the first reset edge).

Structure
REQ-030 Package register_file_pkg SHALL hold default parameter constants and the clog2 function.
REQ-031 Sub-module rf_scoreboard SHALL hold the busy bits: reserve/clear arbitration, busy_vec, per-port busy lookup.
REQ-032 Storage array, write arbitration and read/bypass muxing SHALL stay in register_file_mp.

Verification (defaults unless stated)
REQ-033 Reset 2 cycles, read all 16 addresses -> rd_data 0, busy_vec 16'h0000.
REQ-034 wr0 addr 3 data 4, next cycle rd_addr0=3 -> rd_data0=4; wr1 addr 15 data 16, rd_addr1=15 -> 16.
REQ-035 Same cycle wr0 addr 10 data 8'h11 and wr1 addr 10 data 8'hFF, rd_addr0=10 -> rd_data0=8'hFF that cycle (bypass) and after.
REQ-036 rsv addr 5 -> busy_vec[5]=1, rd_busy for addr 5 =1; then wr0 addr 5 data 7 -> busy 0, data 7; rsv+wr same cycle addr 6 -> busy 1, data stored.
REQ-037 REG_READ=1, BYPASS=0: write addr 2 data 9 and read 2 same cycle -> rd_data 9 one cycle later; ZERO_REG=1 write addr 0 data 5 -> reads 0.
REQ-038 Write addr 4 data 3, rsv addr 4, assert reset mid-sequence with wr0 addr 4 data 1 -> addr 4 reads 0, busy_vec 0.

Source files
------------

// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : register_file_pkg
//  Brief   : Default parameter constants and clog2 helper for register_file_mp.
//  Rev     : 1.0  initial release
// ============================================================================
package register_file_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_REG_READ = 0;
    localparam int DEF_BYPASS   = 1;
    localparam int DEF_ZERO_REG = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module  : rf_scoreboard
//  Brief   : Busy-bit scoreboard: reserve/clear arbitration, busy_vec and
//            per-read-port busy lookup.
//  Rev     : 1.0  initial release
// ============================================================================
module rf_scoreboard
    import register_file_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = clog2(DEF_DEPTH),
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int REG_READ = DEF_REG_READ,
    parameter int BYPASS   = DEF_BYPASS,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Writes clear first, then a reservation sets, so a reserve wins a tie.
    always_comb begin
        busy_d = busy_q;
        if (wr0_en) busy_d[wr0_addr] = 1'b0;
        if (wr1_en) busy_d[wr1_addr] = 1'b0;
        if (rsv_en) busy_d[rsv_addr] = 1'b1;
        if (ZERO_REG != 0) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

    if (REG_READ != 0) begin : g_reg_read
        logic [NUM_RD-1:0] rd_busy_q;
        logic [NUM_RD-1:0] rd_busy_d;

        always_comb begin
            rd_busy_d = '0;
            for (int i = 0; i < NUM_RD; i++) begin
                rd_busy_d[i] = busy_d[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) rd_busy_q <= '0;
            else       rd_busy_q <= rd_busy_d;
        end

        assign rd_busy = rd_busy_q;
    end else begin : g_comb_read
        logic [DEPTH-1:0]  w_busy_src;
        logic [NUM_RD-1:0] w_rd_busy;

        // Forward the post-edge view only outside reset.
        assign w_busy_src = ((BYPASS != 0) && !reset) ? busy_d : busy_q;

        always_comb begin
            w_rd_busy = '0;
            for (int i = 0; i < NUM_RD; i++) begin
                w_rd_busy[i] = w_busy_src[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end

        assign rd_busy = w_rd_busy;
    end

endmodule
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module  : register_file_mp
//  Brief   : Multi-port register file, two prioritised write ports, optional
//            registered read, write-to-read bypass and hardwired zero register.
//  Rev     : 1.0  initial release
// ============================================================================
module register_file_mp
    import register_file_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NUM_RD   = DEF_NUM_RD,
    parameter  int REG_READ = DEF_REG_READ,
    parameter  int BYPASS   = DEF_BYPASS,
    parameter  int ZERO_REG = DEF_ZERO_REG,
    localparam int ADDR_W   = clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // wr1 is applied last so it overrides wr0 on an address collision.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            mem_d[k] = mem_q[k];
        end
        if (wr0_en) mem_d[wr0_addr] = wr0_data;
        if (wr1_en) mem_d[wr1_addr] = wr1_data;
        if (ZERO_REG != 0) mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= mem_d[k];
            end
        end
    end

    if (REG_READ != 0) begin : g_reg_read
        logic [NUM_RD*DATA_W-1:0] rd_data_q;
        logic [NUM_RD*DATA_W-1:0] rd_data_d;

        always_comb begin
            rd_data_d = '0;
            for (int i = 0; i < NUM_RD; i++) begin
                rd_data_d[i*DATA_W +: DATA_W] = mem_d[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) rd_data_q <= '0;
            else       rd_data_q <= rd_data_d;
        end

        assign rd_data = rd_data_q;
    end else begin : g_comb_read
        logic [NUM_RD*DATA_W-1:0] w_rd_data;
        logic                     w_fwd;

        assign w_fwd = (BYPASS != 0) && !reset;

        always_comb begin
            w_rd_data = '0;
            for (int i = 0; i < NUM_RD; i++) begin
                if (w_fwd) w_rd_data[i*DATA_W +: DATA_W] = mem_d[rd_addr[i*ADDR_W +: ADDR_W]];
                else       w_rd_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end

        assign rd_data = w_rd_data;
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .REG_READ (REG_READ),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
//  Module  : tb_register_file_mp
//  Brief   : Directed table-driven bench for register_file_mp (default build
//            plus a registered-read / zero-register build).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_register_file_mp;

    logic        clk;
    logic        reset;

    logic        wr0_en, wr1_en, rsv_en;
    logic [3:0]  wr0_addr, wr1_addr, rsv_addr;
    logic [7:0]  wr0_data, wr1_data;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic [1:0]  rd_busy;
    logic [15:0] busy_vec;

    logic        b_wr0_en, b_wr1_en, b_rsv_en;
    logic [3:0]  b_wr0_addr, b_wr1_addr, b_rsv_addr;
    logic [7:0]  b_wr0_data, b_wr1_data;
    logic [7:0]  b_rd_addr;
    logic [15:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic [15:0] b_busy_vec;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        w0e; logic [3:0] w0a; logic [7:0] w0d;
        logic        w1e; logic [3:0] w1a; logic [7:0] w1d;
        logic        re;  logic [3:0] ra;
        logic [3:0]  a0;  logic [3:0] a1;
        logic [7:0]  e0;  logic [7:0] e1;
        logic [1:0]  eb;  logic [15:0] ev;
    } vec_t;

    vec_t vecs [12];

    register_file_mp dut_a (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    register_file_mp #(
        .REG_READ (1),
        .BYPASS   (0),
        .ZERO_REG (1)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .rd_busy  (b_rd_busy),
        .wr0_en   (b_wr0_en),
        .wr0_addr (b_wr0_addr),
        .wr0_data (b_wr0_data),
        .wr1_en   (b_wr1_en),
        .wr1_addr (b_wr1_addr),
        .wr1_data (b_wr1_data),
        .rsv_en   (b_rsv_en),
        .rsv_addr (b_rsv_addr),
        .busy_vec (b_busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        wr0_en = 1'b0; wr0_addr = 4'd0; wr0_data = 8'h00;
        wr1_en = 1'b0; wr1_addr = 4'd0; wr1_data = 8'h00;
        rsv_en = 1'b0; rsv_addr = 4'd0;
    endtask

    task automatic idle_b();
        b_wr0_en = 1'b0; b_wr0_addr = 4'd0; b_wr0_data = 8'h00;
        b_wr1_en = 1'b0; b_wr1_addr = 4'd0; b_wr1_data = 8'h00;
        b_rsv_en = 1'b0; b_rsv_addr = 4'd0;
    endtask

    initial begin
        //            w0e   w0a    w0d    w1e   w1a    w1d    re    ra    a0     a1     e0     e1     eb     ev
        vecs[0]  = '{1'b1, 4'd3,  8'h04, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd3,  4'd15, 8'h04, 8'h00, 2'b00, 16'h0000};
        vecs[1]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 8'h10, 1'b0, 4'd0, 4'd3,  4'd15, 8'h04, 8'h10, 2'b00, 16'h0000};
        vecs[2]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd3,  4'd15, 8'h04, 8'h10, 2'b00, 16'h0000};
        vecs[3]  = '{1'b1, 4'd10, 8'h11, 1'b1, 4'd10, 8'hFF, 1'b0, 4'd0, 4'd10, 4'd3,  8'hFF, 8'h04, 2'b00, 16'h0000};
        vecs[4]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd10, 4'd15, 8'hFF, 8'h10, 2'b00, 16'h0000};
        vecs[5]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b1, 4'd5, 4'd5,  4'd10, 8'h00, 8'hFF, 2'b01, 16'h0000};
        vecs[6]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd5,  4'd10, 8'h00, 8'hFF, 2'b01, 16'h0020};
        vecs[7]  = '{1'b1, 4'd5,  8'h07, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd5,  4'd10, 8'h07, 8'hFF, 2'b00, 16'h0020};
        vecs[8]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd6,  8'h5A, 1'b1, 4'd6, 4'd6,  4'd5,  8'h5A, 8'h07, 2'b01, 16'h0000};
        vecs[9]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd6,  4'd5,  8'h5A, 8'h07, 2'b01, 16'h0040};
        vecs[10] = '{1'b1, 4'd6,  8'h33, 1'b0, 4'd0,  8'h00, 1'b1, 4'd5, 4'd6,  4'd5,  8'h33, 8'h07, 2'b10, 16'h0040};
        vecs[11] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd6,  4'd5,  8'h33, 8'h07, 2'b10, 16'h0020};

        reset = 1'b1;
        idle_a();
        idle_b();
        rd_addr   = 8'h00;
        b_rd_addr = 8'h00;

        // Reset phase: a write during reset is neither forwarded nor stored.
        step();
        wr0_en = 1'b1; wr0_addr = 4'd1; wr0_data = 8'hAA;
        rd_addr = {4'd0, 4'd1};
        @(negedge clk);
        chk("rst_no_bypass", {16'h0, rd_data}, 32'h0);
        step();
        reset = 1'b0;
        idle_a();

        chk("rst_busy_vec", {16'h0, busy_vec}, 32'h0);
        chk("rst_b_rd_data", {16'h0, b_rd_data}, 32'h0);
        chk("rst_b_busy_vec", {16'h0, b_busy_vec}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            rd_addr = {4'(15 - i), 4'(i)};
            @(negedge clk);
            chk($sformatf("rst_read_%0d", i), {16'h0, rd_data}, 32'h0);
            step();
        end

        // Default build: table of single-cycle vectors.
        for (int n = 0; n < 12; n++) begin
            wr0_en = vecs[n].w0e; wr0_addr = vecs[n].w0a; wr0_data = vecs[n].w0d;
            wr1_en = vecs[n].w1e; wr1_addr = vecs[n].w1a; wr1_data = vecs[n].w1d;
            rsv_en = vecs[n].re;  rsv_addr = vecs[n].ra;
            rd_addr = {vecs[n].a1, vecs[n].a0};
            @(negedge clk);
            chk($sformatf("v%0d_rd0", n),  {24'h0, rd_data[7:0]},  {24'h0, vecs[n].e0});
            chk($sformatf("v%0d_rd1", n),  {24'h0, rd_data[15:8]}, {24'h0, vecs[n].e1});
            chk($sformatf("v%0d_busy", n), {30'h0, rd_busy},       {30'h0, vecs[n].eb});
            chk($sformatf("v%0d_vec", n),  {16'h0, busy_vec},      {16'h0, vecs[n].ev});
            step();
        end
        idle_a();

        // Registered-read build with zero register.
        b_wr0_en = 1'b1; b_wr0_addr = 4'd2; b_wr0_data = 8'h09;
        b_rd_addr = {4'd0, 4'd2};
        @(negedge clk);
        chk("b_rd0_latency", {24'h0, b_rd_data[7:0]}, 32'h0);
        step();
        idle_b();
        @(negedge clk);
        chk("b_rd0_after", {24'h0, b_rd_data[7:0]}, 32'h09);
        step();
        b_wr1_en = 1'b1; b_wr1_addr = 4'd0; b_wr1_data = 8'h05;
        b_rsv_en = 1'b1; b_rsv_addr = 4'd0;
        b_rd_addr = {4'd0, 4'd2};
        step();
        idle_b();
        b_rsv_en = 1'b1; b_rsv_addr = 4'd7;
        b_rd_addr = {4'd7, 4'd0};
        @(negedge clk);
        chk("b_zero_data", {24'h0, b_rd_data[15:8]}, 32'h0);
        chk("b_zero_busy", {31'h0, b_rd_busy[1]}, 32'h0);
        chk("b_zero_vec", {16'h0, b_busy_vec}, 32'h0);
        step();
        idle_b();
        @(negedge clk);
        chk("b_rsv7_busy", {30'h0, b_rd_busy}, 32'h2);
        chk("b_rsv7_data", {16'h0, b_rd_data}, 32'h0);
        chk("b_rsv7_vec", {16'h0, b_busy_vec}, 32'h0080);
        step();

        // Reset in the middle of a write/reserve sequence.
        wr0_en = 1'b1; wr0_addr = 4'd4; wr0_data = 8'h03;
        step();
        idle_a();
        rsv_en = 1'b1; rsv_addr = 4'd4;
        step();
        idle_a();
        reset = 1'b1;
        wr0_en = 1'b1; wr0_addr = 4'd4; wr0_data = 8'h01;
        rsv_en = 1'b1; rsv_addr = 4'd4;
        rd_addr = {4'd10, 4'd4};
        @(negedge clk);
        chk("mid_pre_vec", {16'h0, busy_vec}, 32'h0030);
        chk("mid_rst_comb", {24'h0, rd_data[7:0]}, 32'h03);
        step();
        reset = 1'b0;
        idle_a();
        @(negedge clk);
        chk("mid_post_rd0", {24'h0, rd_data[7:0]}, 32'h0);
        chk("mid_post_rd1", {24'h0, rd_data[15:8]}, 32'h0);
        chk("mid_post_vec", {16'h0, busy_vec}, 32'h0);
        chk("mid_post_busy", {30'h0, rd_busy}, 32'h0);
        step();
        wr0_en = 1'b1; wr0_addr = 4'd4; wr0_data = 8'h09;
        step();
        idle_a();
        @(negedge clk);
        chk("mid_first_write", {24'h0, rd_data[7:0]}, 32'h09);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
